// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller.
package pipe_pkg;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {RUN, DMEM_WAIT, ERR} state_e;

    typedef struct packed {
        logic wen;
        logic flush;
    } stage_ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline, with
// data-memory timeout detection and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  mem_memread_i,
    input  logic                  mem_memwrite_i,
    input  logic                  mem_branch_i,
    input  logic                  mem_zero_i,
    input  logic                  dmem_ready_i,
    input  logic                  imem_ready_i,
    output logic                  pc_wen_o,
    output logic                  ifid_wen_o,
    output logic                  idex_wen_o,
    output logic                  exmem_wen_o,
    output logic                  memwb_wen_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  exmem_flush_o,
    output logic                  memwb_flush_o,
    output logic                  dmem_req_o,
    output logic                  mem_timeout_err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);
    import pipe_pkg::*;

    localparam int WW = $clog2(MEM_TIMEOUT);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          acc, taken, lu, freeze, active, pc_wen;
    stage_ctrl_t   ifid, idex, exmem, memwb;

    assign acc    = mem_memread_i | mem_memwrite_i;
    assign taken  = mem_branch_i & mem_zero_i;
    assign lu     = ex_memread_i && (ex_rt_i != '0) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
    assign freeze = acc & ~dmem_ready_i;
    assign active = reset_ni && (state_q != ERR);

    always_comb begin
        pc_wen     = 1'b0;
        ifid       = '0;
        idex       = '0;
        exmem      = '0;
        memwb      = '0;
        dmem_req_o = 1'b0;
        if (active) begin
            dmem_req_o = acc;
            if (freeze) begin
                // Only a bubble advances into WB so the held MEM result is not written twice.
                memwb = '{1'b1, 1'b1};
            end else if (taken) begin
                pc_wen = 1'b1;
                ifid   = '{1'b1, 1'b1};
                idex   = '{1'b1, 1'b1};
                exmem  = '{1'b1, 1'b1};
                memwb  = '{1'b1, 1'b0};
            end else if (lu) begin
                idex  = '{1'b1, 1'b1};
                exmem = '{1'b1, 1'b0};
                memwb = '{1'b1, 1'b0};
            end else begin
                pc_wen = imem_ready_i;
                ifid   = '{1'b1, ~imem_ready_i};
                idex   = '{1'b1, 1'b0};
                exmem  = '{1'b1, 1'b0};
                memwb  = '{1'b1, 1'b0};
            end
        end
    end

    assign pc_wen_o          = pc_wen;
    assign ifid_wen_o        = ifid.wen;
    assign idex_wen_o        = idex.wen;
    assign exmem_wen_o       = exmem.wen;
    assign memwb_wen_o       = memwb.wen;
    assign ifid_flush_o      = ifid.flush;
    assign idex_flush_o      = idex.flush;
    assign exmem_flush_o     = exmem.flush;
    assign memwb_flush_o     = memwb.flush;
    assign mem_timeout_err_o = (state_q == ERR);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = DMEM_WAIT;
                    wait_d  = WW'(1);
                end
            end
            DMEM_WAIT: begin
                // A ready in the limit cycle clears freeze and therefore wins over the timeout.
                if (!freeze) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .inc_i  (reset_ni & ~pc_wen),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .inc_i  (active & ~freeze & taken),
        .cnt_o  (flush_cnt_o)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int SAT = 15;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic ex_memread, mem_memread, mem_memwrite, mem_branch, mem_zero, dmem_ready, imem_ready;
    logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0, errors = 0;
    int m_wait = 0, m_stall = 0, m_flush = 0;
    logic m_err = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .mem_memread_i(mem_memread), .mem_memwrite_i(mem_memwrite),
        .mem_branch_i(mem_branch), .mem_zero_i(mem_zero),
        .dmem_ready_i(dmem_ready), .imem_ready_i(imem_ready),
        .pc_wen_o(pc_wen), .ifid_wen_o(ifid_wen), .idex_wen_o(idex_wen),
        .exmem_wen_o(exmem_wen), .memwb_wen_o(memwb_wen),
        .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
        .exmem_flush_o(exmem_flush), .memwb_flush_o(memwb_flush),
        .dmem_req_o(dmem_req), .mem_timeout_err_o(err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Expected {pc,ifid,idex,exmem,memwb wen | ifid,idex,exmem,memwb flush | dmem_req | err}.
    function automatic logic [10:0] model_ctrl(output logic [10:0] mask);
        logic acc, lu;
        acc  = mem_memread | mem_memwrite;
        lu   = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        mask = 11'h7ff;
        if (!rst_n || m_err) return {10'b0, m_err & rst_n};
        if (acc && !dmem_ready) return 11'b00001_0001_1_0;
        if (mem_branch && mem_zero) return {9'b11111_1110, acc, 1'b0};
        if (lu) begin
            mask[8] = 1'b0;
            return {9'b00011_0100, acc, 1'b0};
        end
        if (!imem_ready) return {9'b01111_1000, acc, 1'b0};
        return {9'b11111_0000, acc, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(output logic [10:0] e);
        logic [10:0] mask, obs;
        e   = model_ctrl(mask);
        obs = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, err};
        chk("ctrl", 32'(obs & mask), 32'(e & mask));
        chk("err", 32'(err), 32'(e[0]));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic model_edge(input logic [10:0] e);
        if (!rst_n) return;
        if (!e[10] && m_stall < SAT) m_stall++;
        if (!m_err) begin
            if ((mem_memread || mem_memwrite) && !dmem_ready) begin
                m_wait++;
                if (m_wait == TO) m_err = 1'b1;
            end else begin
                m_wait = 0;
                if (mem_branch && mem_zero && m_flush < SAT) m_flush++;
            end
        end
    endtask

    // Inputs are driven at posedge+1; outputs checked at negedge; model steps at posedge.
    task automatic cyc();
        logic [10:0] e;
        @(negedge clk);
        check_all(e);
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3; ex_memread = 1'b0;
        mem_memread = 1'b0; mem_memwrite = 1'b0; mem_branch = 1'b0; mem_zero = 1'b0;
        dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    task automatic async_rst();
        logic [10:0] e;
        #1 rst_n = 1'b0;
        m_err = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
        #1 check_all(e);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [10:0] e;
        idle();
        #2 check_all(e);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        ex_memread = 1'b0;
        cyc();

        ex_memread = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
        cyc();
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 1);
        idle();

        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        cyc();
        idle();

        mem_memread = 1'b1; dmem_ready = 1'b0; mem_branch = 1'b1; mem_zero = 1'b1;
        repeat (3) cyc();
        dmem_ready = 1'b1;
        cyc();
        chk("dmem_stall_cnt", 32'(stall_cnt), 4);
        chk("dmem_flush_cnt", 32'(flush_cnt), 2);
        idle();

        ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; imem_ready = 1'b0;
        cyc();
        chk("lu_imem_stall", 32'(stall_cnt), 5);
        idle();

        imem_ready = 1'b0;
        repeat (2) cyc();
        chk("imem_stall_cnt", 32'(stall_cnt), 7);
        idle();

        mem_memwrite = 1'b1; dmem_ready = 1'b0;
        repeat (3) cyc();
        dmem_ready = 1'b1;
        cyc();
        chk("limit_ready_err", 32'(err), 0);
        chk("limit_ready_stall", 32'(stall_cnt), 10);

        dmem_ready = 1'b0;
        repeat (4) cyc();
        chk("timeout_err", 32'(err), 1);
        chk("timeout_stall", 32'(stall_cnt), 14);
        dmem_ready = 1'b1;
        repeat (2) cyc();
        chk("sticky_err", 32'(err), 1);
        chk("stall_saturated", 32'(stall_cnt), SAT);

        async_rst();
        mem_memread = 1'b1; mem_memwrite = 1'b0; dmem_ready = 1'b0;
        repeat (2) cyc();
        async_rst();
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        idle();
        cyc();
        chk("post_rst_pc_wen", 32'(pc_wen), 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(59) == 0) begin
                async_rst();
            end else begin
                id_rs        = 5'($urandom_range(7));
                id_rt        = 5'($urandom_range(7));
                ex_rt        = 5'($urandom_range(7));
                ex_memread   = 1'($urandom_range(1));
                mem_memread  = ($urandom_range(3) == 0);
                mem_memwrite = ($urandom_range(5) == 0);
                mem_branch   = ($urandom_range(2) == 0);
                mem_zero     = 1'($urandom_range(1));
                dmem_ready   = ($urandom_range(2) != 0);
                imem_ready   = ($urandom_range(3) != 0);
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives wen and flush of the IF/ID, ID/EX, EX/MEM and MEM/WB control/data pipe registers, plus PC write enable.
- Detects load-use hazards, flushes on branches resolved in MEM, freezes on multi-cycle data-memory access and bubbles on instruction-memory wait.
- Keeps a sticky timeout error and saturating stall/flush statistics counters.

Parameters:
REG_ADDR_W, 5, register-specifier width
MEM_TIMEOUT, 16, max consecutive dmem wait cycles before error (>=2)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  REG_ADDR_W  rs field of instruction in IF/ID
id_rt  in  REG_ADDR_W  rt field of instruction in IF/ID
ex_memread  in  1  MemRead held in ID/EX
ex_rt  in  REG_ADDR_W  destination rt held in ID/EX
mem_memread  in  1  MemRead_o of EX/MEM
mem_memwrite  in  1  MemWrite_o of EX/MEM
mem_branch  in  1  Branch_o of EX/MEM
mem_zero  in  1  ALU zero held in EX/MEM
dmem_ready  in  1  data memory completes access this cycle
imem_ready  in  1  instruction memory returns valid word this cycle
pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  register write enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous bubble insert
dmem_req  out  1  data access request
mem_timeout_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_wen=0
flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Reset (reset=0, async):
  - State=RUN, wait_cnt=0, mem_timeout_err=0, stall_cnt=0, flush_cnt=0.
  - While reset is low, all wen=0, all flush=0 and dmem_req=0.
- Control outputs are combinational from state and inputs. State and counters update on posedge clk.
- States are RUN, DMEM_WAIT and ERR.
- Derived terms:
  - acc = mem_memread | mem_memwrite.
  - taken = mem_branch & mem_zero.
  - lu = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- dmem_req = acc, in RUN or DMEM_WAIT.
- Priority, highest first:
  1. ERR: all wen=0, flush=0, dmem_req=0, mem_timeout_err=1. Stays in ERR until reset.
  2. Freeze, when acc & !dmem_ready:
     - All wen=0 except memwb_wen=1, with memwb_flush=1 (a bubble enters WB, no duplicate writeback).
     - Branch and load-use are not acted on; they are re-evaluated after release.
  3. Branch taken:
     - All wen=1 and pc_wen=1 (the PC mux selects the target).
     - ifid_flush=1, idex_flush=1, exmem_flush=1.
     - flush_cnt+1.
     - Overrides lu and imem wait.
  4. Load-use:
     - pc_wen=0 and ifid_wen=0.
     - idex_flush=1 (one bubble).
     - exmem_wen=1 and memwb_wen=1.
     - Exactly 1 stall cycle per hazard, because the bubble clears ex_memread.
  5. imem wait (!imem_ready): pc_wen=0, ifid_flush=1, all other wen=1.
  6. Otherwise: all wen=1, all flush=0.
- FSM transitions:
  - RUN to DMEM_WAIT on freeze, with wait_cnt set to 1.
  - DMEM_WAIT stays in DMEM_WAIT while freeze holds, with wait_cnt+1.
  - DMEM_WAIT to RUN in the cycle dmem_ready=1. Normal priorities apply in that same cycle, so release adds 0 extra latency.
  - Freeze with wait_cnt == MEM_TIMEOUT-1 goes to ERR.
  - ready arriving in the same cycle as the limit wins, and the FSM returns to RUN.
- Counters:
  - stall_cnt increments in every cycle with reset high and pc_wen=0, including ERR.
  - Both counters saturate at all-ones.
- ex_rt=0 never stalls.
- Simultaneous lu and imem wait: pc_wen=0, ifid_wen=0, idex_flush=1. This is the lu case; ifid_flush stays 0.

Decomposition:
- Shared pipe_pkg holds:
  - The state enum (RUN, DMEM_WAIT, ERR).
  - REG_ADDR_W.
  - A stage-control struct {wen, flush}.
- One natural sub-module, sat_counter (CNT_W, inc, async active-low clear), instantiated twice.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_wen=0, ifid_wen=0, idex_flush=1, stall_cnt=1. Next cycle (ex_memread=0) all wen=1.
- Branch: mem_branch=1, mem_zero=1 together with lu active -> ifid/idex/exmem_flush=1, pc_wen=1, flush_cnt=1, stall_cnt unchanged.
- Dmem wait: mem_memread=1, dmem_ready=0 for 3 cycles then 1 -> all wen=0 except memwb_wen=1 with memwb_flush=1 for 3 cycles; release in cycle 4; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_memwrite=1, dmem_ready held 0 -> ERR after 4 cycles; mem_timeout_err=1 sticky; dmem_ready=1 afterwards does not clear it.
- Async reset mid-freeze: reset=0 between clock edges -> immediately all wen=0, err=0, counters 0. After release, state=RUN.
- imem wait: imem_ready=0 for 2 cycles -> pc_wen=0 and ifid_flush=1 for 2 cycles, idex/exmem/memwb_wen=1, stall_cnt=2.
